// File: rtl/seq_signed_divider_pkg.sv
// Shared ALU divider definitions: state encoding, step-count convention and the
// conditional-negate helper used for operand magnitudes and result sign fixup.
package seq_signed_divider_pkg;

    localparam int unsigned DIV_BITS  = 4;
    localparam int unsigned DIV_STEPS = DIV_BITS;
    localparam int unsigned NEG_W     = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIVIDE = 2'd1,
        ST_FIXUP  = 2'd2
    } div_state_e;

    // Two's-complement negate when neg is set; callers zero-extend and truncate.
    function automatic logic [NEG_W-1:0] cond_neg(input logic [NEG_W-1:0] x, input logic neg);
        return neg ? (~x + NEG_W'(1)) : x;
    endfunction

endpackage

// File: rtl/seq_signed_divider_if.sv
// Start/result handshake bundle between a requester (master) and the divider (slave).
interface seq_signed_divider_if
    import seq_signed_divider_pkg::*;
#(
    parameter int unsigned BITS = DIV_BITS
);
    logic            start;
    logic [BITS-1:0] dividend;
    logic [BITS-1:0] divisor;
    logic            ready;
    logic            done;
    logic [BITS-1:0] quotient;
    logic [BITS-1:0] remainder;
    logic            div_zero;
    logic            overflow;

    modport master (
        output start, dividend, divisor,
        input  ready, done, quotient, remainder, div_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output ready, done, quotient, remainder, div_zero, overflow
    );
endinterface

// File: rtl/seq_signed_divider_cla_subtractor.sv
// Carry-lookahead A - B computed as A + ~B + 1; borrow is the inverted carry-out.
module cla_subtractor #(
    parameter int unsigned W = 5
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] diff_o,
    output logic         borrow_o
);
    logic [W-1:0] b_n;
    logic [W-1:0] p;
    logic [W-1:0] g;
    logic [W:0]   c;
    logic         acc;
    logic         run;

    assign b_n = ~b_i;
    assign p   = a_i ^ b_n;
    assign g   = a_i & b_n;

    // Each carry is a flat sum of generate terms gated by the propagate chain above them.
    always_comb begin
        c    = '0;
        acc  = 1'b0;
        run  = 1'b1;
        c[0] = 1'b1;
        for (int i = 0; i < int'(W); i++) begin
            acc = 1'b0;
            run = 1'b1;
            for (int j = i; j >= 0; j--) begin
                acc = acc | (run & g[j]);
                run = run & p[j];
            end
            c[i+1] = acc | run;
        end
    end

    assign diff_o   = p ^ c[W-1:0];
    assign borrow_o = ~c[W];
endmodule

// File: rtl/seq_signed_divider.sv
// Multi-cycle signed restoring divider: one shift-subtract step per clock,
// truncating quotient and dividend-signed remainder with a one-cycle done pulse.
module seq_signed_divider
    import seq_signed_divider_pkg::*;
#(
    parameter int unsigned BITS = DIV_BITS
) (
    input logic                 clk,
    input logic                 rst,
    seq_signed_divider_if.slave bus
);
    localparam int unsigned   STEPS   = BITS;
    localparam int unsigned   CNT_W   = $clog2(STEPS);
    localparam logic [1:0]    IDLE    = ST_IDLE;
    localparam logic [1:0]    DIVIDE  = ST_DIVIDE;
    localparam logic [1:0]    FIXUP   = ST_FIXUP;
    localparam logic [BITS-1:0] MIN_NEG = {1'b1, {(BITS-1){1'b0}}};

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BITS-1:0]  rem_q, rem_d;
    logic [BITS-1:0]  dvd_q, dvd_d;
    logic [BITS-1:0]  dvs_q, dvs_d;
    logic             sgn_q_q, sgn_q_d;
    logic             sgn_r_q, sgn_r_d;
    logic             dz_pend_q, dz_pend_d;
    logic             ovf_pend_q, ovf_pend_d;
    logic [BITS-1:0]  quot_q, quot_d;
    logic [BITS-1:0]  rmd_q, rmd_d;
    logic             dz_q, dz_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [BITS:0]    shifted;
    logic [BITS:0]    diff;
    logic             borrow;

    // dvd_q starts as |dividend| and fills with quotient bits from the LSB side.
    assign shifted = {rem_q, dvd_q[BITS-1]};

    cla_subtractor #(.W(BITS + 1)) u_sub (
        .a_i      (shifted),
        .b_i      ({1'b0, dvs_q}),
        .diff_o   (diff),
        .borrow_o (borrow)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        sgn_q_d    = sgn_q_q;
        sgn_r_d    = sgn_r_q;
        dz_pend_d  = dz_pend_q;
        ovf_pend_d = ovf_pend_q;
        quot_d     = quot_q;
        rmd_d      = rmd_q;
        dz_d       = dz_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    dvd_d      = BITS'(cond_neg(NEG_W'(bus.dividend), bus.dividend[BITS-1]));
                    dvs_d      = BITS'(cond_neg(NEG_W'(bus.divisor), bus.divisor[BITS-1]));
                    rem_d      = '0;
                    sgn_q_d    = bus.dividend[BITS-1] ^ bus.divisor[BITS-1];
                    sgn_r_d    = bus.dividend[BITS-1];
                    dz_pend_d  = (bus.divisor == '0);
                    ovf_pend_d = (bus.dividend == MIN_NEG) && (bus.divisor == '1);
                    cnt_d      = CNT_W'(STEPS - 1);
                    state_d    = DIVIDE;
                end
            end
            DIVIDE: begin
                if (!borrow) begin
                    rem_d = BITS'(diff);
                    dvd_d = {dvd_q[BITS-2:0], 1'b1};
                end else begin
                    rem_d = BITS'(shifted);
                    dvd_d = {dvd_q[BITS-2:0], 1'b0};
                end
                cnt_d = CNT_W'(cnt_q - 1'b1);
                if (cnt_q == '0) begin
                    state_d = FIXUP;
                end
            end
            FIXUP: begin
                quot_d  = BITS'(cond_neg(NEG_W'(dvd_q), sgn_q_q));
                rmd_d   = BITS'(cond_neg(NEG_W'(rem_q), sgn_r_q));
                dz_d    = dz_pend_q;
                ovf_d   = ovf_pend_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            sgn_q_q    <= 1'b0;
            sgn_r_q    <= 1'b0;
            dz_pend_q  <= 1'b0;
            ovf_pend_q <= 1'b0;
            quot_q     <= '0;
            rmd_q      <= '0;
            dz_q       <= 1'b0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            sgn_q_q    <= sgn_q_d;
            sgn_r_q    <= sgn_r_d;
            dz_pend_q  <= dz_pend_d;
            ovf_pend_q <= ovf_pend_d;
            quot_q     <= quot_d;
            rmd_q      <= rmd_d;
            dz_q       <= dz_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
        end
    end

    assign bus.ready     = (state_q == IDLE);
    assign bus.done      = done_q;
    assign bus.quotient  = quot_q;
    assign bus.remainder = rmd_q;
    assign bus.div_zero  = dz_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_seq_signed_divider.sv
// Scoreboard bench for seq_signed_divider at 4 bits: directed operand pairs,
// busy-start rejection, back-to-back issue and mid-operation reset abort.
module tb_seq_signed_divider;
    import seq_signed_divider_pkg::*;

    localparam int LAT = int'(DIV_STEPS) + 1;

    typedef struct {
        logic [3:0] q;
        logic [3:0] r;
        logic       dz;
        logic       ov;
        int         acc;
        string      nm;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sb[$];
    exp_t mon_e;

    seq_signed_divider_if #(.BITS(4)) bus ();

    seq_signed_divider #(.BITS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!rst && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(bus.done), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.nm, "_quot"}, 32'(bus.quotient), 32'(mon_e.q));
                check({mon_e.nm, "_rem"},  32'(bus.remainder), 32'(mon_e.r));
                check({mon_e.nm, "_dz"},   32'(bus.div_zero), 32'(mon_e.dz));
                check({mon_e.nm, "_ovf"},  32'(bus.overflow), 32'(mon_e.ov));
                check({mon_e.nm, "_lat"},  32'(cyc - mon_e.acc), 32'(LAT));
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic push,
                         input logic [3:0] eq, input logic [3:0] er,
                         input logic edz, input logic eov, input string nm);
        exp_t e;
        int   n;
        n = 0;
        while (bus.ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_ready"}, 32'(bus.ready), 32'd1);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1;
        if (push) begin
            e.q = eq; e.r = er; e.dz = edz; e.ov = eov; e.acc = cyc; e.nm = nm;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int n;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_done",  32'(bus.done), 32'd0);
        check("rst_quot",  32'(bus.quotient), 32'd0);
        check("rst_rem",   32'(bus.remainder), 32'd0);
        check("rst_dz",    32'(bus.div_zero), 32'd0);
        check("rst_ovf",   32'(bus.overflow), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        issue(4'h7, 4'h2, 1'b1, 4'h3, 4'h1, 1'b0, 1'b0, "p7_d2");   drain();
        issue(4'h9, 4'h2, 1'b1, 4'hD, 4'hF, 1'b0, 1'b0, "m7_d2");   drain();
        issue(4'h7, 4'hE, 1'b1, 4'hD, 4'h1, 1'b0, 1'b0, "p7_dm2");  drain();
        issue(4'h8, 4'hF, 1'b1, 4'h8, 4'h0, 1'b0, 1'b1, "m8_dm1");  drain();
        issue(4'h8, 4'h1, 1'b1, 4'h8, 4'h0, 1'b0, 1'b0, "m8_d1");   drain();
        issue(4'h5, 4'h0, 1'b1, 4'hF, 4'h5, 1'b1, 1'b0, "p5_d0");   drain();

        // A start while busy must be dropped; a start in the done cycle is taken.
        issue(4'h7, 4'h2, 1'b1, 4'h3, 4'h1, 1'b0, 1'b0, "busy_p7_d2");
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 4'h6;
        bus.divisor  = 4'h3;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (bus.done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 32'(bus.done), 32'd1);
        check("ready_with_done", 32'(bus.ready), 32'd1);
        issue(4'h6, 4'h3, 1'b1, 4'h2, 4'h0, 1'b0, 1'b0, "b2b_p6_d3");
        drain();

        // Abort -7/3 two cycles in.
        issue(4'h9, 4'h3, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, "abort_m7_d3");
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_quot",  32'(bus.quotient), 32'd0);
        check("abort_rem",   32'(bus.remainder), 32'd0);
        check("abort_dz",    32'(bus.div_zero), 32'd0);
        check("abort_ovf",   32'(bus.overflow), 32'd0);
        check("abort_done",  32'(bus.done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready", 32'(bus.ready), 32'd1);
        repeat (8) begin
            @(negedge clk);
            check("abort_no_done", 32'(bus.done), 32'd0);
        end

        issue(4'h4, 4'hD, 1'b1, 4'hF, 4'h1, 1'b0, 1'b0, "p4_dm3");
        drain();

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
